// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op_e    : operation encodings driven by the control unit
//   state_e : sequencer states
//   clog2   : ceiling log2, used to size the step counter
package mips_muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/mips_muldiv_iter_if.sv
// Request/result bundle between the control unit (master) and the
// multiply/divide unit (slave).
//   i_start, i_op, i_s, i_t : request, sampled with i_start
//   i_abort                 : only with MIPS_MULDIV_ABORT_EN defined
//   o_busy, o_done          : status
//   o_y_hi, o_y_lo          : HI/LO results
//   o_div_by_zero, o_n, o_z : result flags
interface mips_muldiv_iter_if
   import mips_muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) ();

   logic             i_start;
   op_e              i_op;
   logic [WIDTH-1:0] i_s;
   logic [WIDTH-1:0] i_t;
`ifdef MIPS_MULDIV_ABORT_EN
   logic             i_abort;
`endif
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_y_hi;
   logic [WIDTH-1:0] o_y_lo;
   logic             o_div_by_zero;
   logic             o_n;
   logic             o_z;

`ifdef MIPS_MULDIV_ABORT_EN
   modport master (output i_start, i_op, i_s, i_t, i_abort,
                   input  o_busy, o_done, o_y_hi, o_y_lo, o_div_by_zero, o_n, o_z);
   modport slave  (input  i_start, i_op, i_s, i_t, i_abort,
                   output o_busy, o_done, o_y_hi, o_y_lo, o_div_by_zero, o_n, o_z);
`else
   modport master (output i_start, i_op, i_s, i_t,
                   input  o_busy, o_done, o_y_hi, o_y_lo, o_div_by_zero, o_n, o_z);
   modport slave  (input  i_start, i_op, i_s, i_t,
                   output o_busy, o_done, o_y_hi, o_y_lo, o_div_by_zero, o_n, o_z);
`endif

endinterface

// File: rtl/mips_muldiv_signfix.sv
// Conditional two's-complement negation.
//   i_val : input value
//   i_neg : 1 = return -i_val, 0 = return i_val
//   o_val : result
module mips_muldiv_signfix #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_val,
   input  logic             i_neg,
   output logic [WIDTH-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mips_muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO results.
// Radix-2 shift-add multiplier and restoring divider share one WIDTH+1 bit
// accumulator; signed ops run on magnitudes and are corrected in FIX.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : mips_muldiv_iter_if slave (request, status, results, flags)
// Optional feature: MIPS_MULDIV_ABORT_EN adds bus.i_abort, which drops an
// in-flight operation back to IDLE without a done pulse.
module mips_muldiv_iter
   import mips_muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   mips_muldiv_iter_if.slave bus
);

   localparam int unsigned CW = clog2(WIDTH + 1);

   state_e           r_state;
   op_e              r_op;
   logic [WIDTH:0]   r_acc;    // upper product half / partial remainder
   logic [WIDTH-1:0] r_lo;     // multiplier -> lower product / dividend -> quotient
   logic [WIDTH-1:0] r_b;      // multiplicand / divisor
   logic [CW-1:0]    r_cnt;
   logic             r_neg_q;  // negate product or quotient
   logic             r_neg_r;  // negate remainder (sign of S)
   logic             r_dbz;
   logic             r_busy;
   logic             r_done;
   logic             r_dbz_o;
   logic             r_n;
   logic             r_z;
   logic [WIDTH-1:0] r_y_hi;
   logic [WIDTH-1:0] r_y_lo;

   logic [1:0]         w_op;
   logic               w_signed_op;
   logic               w_div_op;
   logic               w_r_div;
   logic               w_abort;
   logic [WIDTH-1:0]   w_s_mag;
   logic [WIDTH-1:0]   w_t_mag;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_shl;
   logic [WIDTH+1:0]   w_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_y_hi;
   logic [WIDTH-1:0]   w_y_lo;
   logic               w_n;
   logic               w_z;

   assign w_op        = bus.i_op;
   assign w_signed_op = (w_op == OP_MULT) || (w_op == OP_DIV);
   assign w_div_op    = (w_op == OP_DIV) || (w_op == OP_DIVU);
   assign w_r_div     = (r_op == OP_DIV) || (r_op == OP_DIVU);

`ifdef MIPS_MULDIV_ABORT_EN
   assign w_abort = bus.i_abort;
`else
   assign w_abort = 1'b0;
`endif

   mips_muldiv_signfix #(.WIDTH(WIDTH)) u_s_mag (
      .i_val (bus.i_s),
      .i_neg (w_signed_op & bus.i_s[WIDTH-1]),
      .o_val (w_s_mag)
   );

   mips_muldiv_signfix #(.WIDTH(WIDTH)) u_t_mag (
      .i_val (bus.i_t),
      .i_neg (w_signed_op & bus.i_t[WIDTH-1]),
      .o_val (w_t_mag)
   );

   // Multiply step: acc[WIDTH] is always 0 here, so the sum cannot overflow.
   assign w_sum  = r_acc + {1'b0, (r_lo[0] ? r_b : {WIDTH{1'b0}})};
   // Divide step: shifted remainder and trial subtract; MSB of w_diff is the borrow.
   assign w_shl  = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
   assign w_diff = {1'b0, w_shl} - {2'b00, r_b};

   mips_muldiv_signfix #(.WIDTH(2*WIDTH)) u_prod (
      .i_val ({r_acc[WIDTH-1:0], r_lo}),
      .i_neg (r_neg_q),
      .o_val (w_prod)
   );

   mips_muldiv_signfix #(.WIDTH(WIDTH)) u_quot (
      .i_val (r_lo),
      .i_neg (r_neg_q),
      .o_val (w_quot)
   );

   mips_muldiv_signfix #(.WIDTH(WIDTH)) u_rem (
      .i_val (r_acc[WIDTH-1:0]),
      .i_neg (r_neg_r),
      .o_val (w_rem)
   );

   always_comb begin
      w_y_hi = w_rem;
      w_y_lo = w_quot;
      if (r_dbz) begin
         // Divide by zero: raw dividend and all-ones quotient were parked at start.
         w_y_hi = r_acc[WIDTH-1:0];
         w_y_lo = r_lo;
      end else if (!w_r_div) begin
         w_y_hi = w_prod[2*WIDTH-1:WIDTH];
         w_y_lo = w_prod[WIDTH-1:0];
      end
      w_n = w_r_div ? w_y_lo[WIDTH-1] : w_y_hi[WIDTH-1];
      w_z = w_r_div ? (w_y_lo == '0) : ({w_y_hi, w_y_lo} == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_op    <= OP_MULT;
         r_acc   <= '0;
         r_lo    <= '0;
         r_b     <= '0;
         r_cnt   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dbz   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz_o <= 1'b0;
         r_n     <= 1'b0;
         r_z     <= 1'b0;
         r_y_hi  <= '0;
         r_y_lo  <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE, DONE: begin
               if (bus.i_start) begin
                  r_op    <= bus.i_op;
                  r_neg_q <= w_signed_op & (bus.i_s[WIDTH-1] ^ bus.i_t[WIDTH-1]);
                  r_neg_r <= w_signed_op & bus.i_s[WIDTH-1];
                  r_cnt   <= CW'(WIDTH);
                  r_busy  <= 1'b1;
                  if (w_div_op && (bus.i_t == '0)) begin
                     r_dbz   <= 1'b1;
                     r_acc   <= {1'b0, bus.i_s};
                     r_lo    <= '1;
                     r_b     <= '0;
                     r_state <= FIX;
                  end else begin
                     r_dbz   <= 1'b0;
                     r_acc   <= '0;
                     r_lo    <= w_div_op ? w_s_mag : w_t_mag;
                     r_b     <= w_div_op ? w_t_mag : w_s_mag;
                     r_state <= RUN;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               if (w_abort) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (r_cnt == '0) begin
                  r_state <= FIX;
               end else begin
                  if (w_r_div) begin
                     if (w_diff[WIDTH+1]) begin
                        r_acc <= w_shl;
                        r_lo  <= {r_lo[WIDTH-2:0], 1'b0};
                     end else begin
                        r_acc <= w_diff[WIDTH:0];
                        r_lo  <= {r_lo[WIDTH-2:0], 1'b1};
                     end
                  end else begin
                     r_acc <= {1'b0, w_sum[WIDTH:1]};
                     r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
                  end
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            FIX: begin
               r_busy <= 1'b0;
               if (w_abort) begin
                  r_state <= IDLE;
               end else begin
                  r_y_hi  <= w_y_hi;
                  r_y_lo  <= w_y_lo;
                  r_n     <= w_n;
                  r_z     <= w_z;
                  r_dbz_o <= r_dbz;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.o_busy        = r_busy;
   assign bus.o_done        = r_done;
   assign bus.o_y_hi        = r_y_hi;
   assign bus.o_y_lo        = r_y_lo;
   assign bus.o_div_by_zero = r_dbz_o;
   assign bus.o_n           = r_n;
   assign bus.o_z           = r_z;

endmodule

// File: tb/tb_mips_muldiv_iter.sv
// Scoreboard bench for mips_muldiv_iter (WIDTH=32): the driver pushes the
// hand-computed result and expected done cycle; a negedge monitor pops and
// compares whenever done is high.
module tb_mips_muldiv_iter;
   import mips_muldiv_pkg::*;

   localparam int unsigned W = 32;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      logic        n;
      logic        z;
      int unsigned cyc;
   } exp_t;

   logic        clk;
   logic        reset_n;
   int unsigned cyc;
   int unsigned n_vec;
   int unsigned n_err;
   int unsigned n_done;
   int unsigned n_pushed;
   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned e0;
   int unsigned e0b;

   mips_muldiv_iter_if #(.WIDTH(W)) bus ();

   mips_muldiv_iter #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] outs();
      return 128'({bus.o_y_hi, bus.o_y_lo, bus.o_div_by_zero, bus.o_n, bus.o_z});
   endfunction

   // Monitor: compare every done pulse against the oldest expectation.
   always @(negedge clk) begin
      if (reset_n && bus.o_done) begin
         n_done++;
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, "_result"}, outs(),
                  128'({mon_e.hi, mon_e.lo, mon_e.dbz, mon_e.n, mon_e.z}));
            check({mon_e.name, "_latency"}, 128'(cyc), 128'(mon_e.cyc));
         end
      end
   end

   // Drive one request at a negedge; start is sampled at the following edge e0.
   task automatic issue(input string name, input op_e op, input logic [31:0] s,
                        input logic [31:0] t, input logic [31:0] hi, input logic [31:0] lo,
                        input logic dbz, input logic n, input logic z, input bit push,
                        output int unsigned start_edge);
      exp_t e;
      bus.i_start = 1'b1;
      bus.i_op    = op;
      bus.i_s     = s;
      bus.i_t     = t;
      start_edge  = cyc + 1;
      if (push) begin
         e.name = name;
         e.hi   = hi;
         e.lo   = lo;
         e.dbz  = dbz;
         e.n    = n;
         e.z    = z;
         e.cyc  = start_edge + (dbz ? 1 : W + 2);
         sb.push_back(e);
         n_pushed++;
      end
      @(negedge clk);
      bus.i_start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (!bus.o_done && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!bus.o_done) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_timeout: got no done in 100 cycles, expected done", name);
      end
   endtask

   task automatic run(input string name, input op_e op, input logic [31:0] s,
                      input logic [31:0] t, input logic [31:0] hi, input logic [31:0] lo,
                      input logic dbz, input logic n, input logic z);
      int unsigned st;
      issue(name, op, s, t, hi, lo, dbz, n, z, 1'b1, st);
      wait_done(name);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      n_vec = 0; n_err = 0; n_done = 0; n_pushed = 0;
      reset_n     = 1'b0;
      bus.i_start = 1'b0;
      bus.i_op    = OP_MULT;
      bus.i_s     = '0;
      bus.i_t     = '0;
`ifdef MIPS_MULDIV_ABORT_EN
      bus.i_abort = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("reset_outputs", 128'({bus.o_busy, bus.o_done, outs()}), 128'(0));
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run("mult_neg3x7",   OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 1, 0);
      run("multu_max",     OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 1, 0);
      run("div_neg7_2",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1, 0);
      run("divu_100_7",    OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 0, 0, 0);
      run("divu_by_zero",  OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1, 1, 0);
      run("div_minneg",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 1, 0);
      run("mult_zero",     OP_MULT,  32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 0, 0, 1);
      run("div_7_neg2",    OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 1, 0);
      run("mult_neg_neg",  OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 0, 0, 0);
      run("div_by_zero",   OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1, 1, 0);
      run("divu_5_9",      OP_DIVU,  32'h00000005, 32'h00000009, 32'h00000005, 32'h00000000, 0, 0, 1);
      run("mult_max_min",  OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 0, 1, 0);

      // Back-to-back: second start driven in the first op's done cycle.
      issue("b2b_first", OP_MULTU, 32'd3, 32'd5, 32'h0, 32'h0000000F, 0, 0, 0, 1'b1, e0);
      wait_done("b2b_first");
      issue("b2b_second", OP_DIVU, 32'd100, 32'd7, 32'h2, 32'h0000000E, 0, 0, 0, 1'b1, e0b);
      wait_done("b2b_second");
      repeat (2) @(negedge clk);

      // Starts while busy (RUN and FIX) must be dropped.
      issue("busy_ignore", OP_MULT, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 1, 0,
            1'b1, e0);
      repeat (4) @(negedge clk);
      bus.i_start = 1'b1; bus.i_op = OP_DIVU; bus.i_s = 32'd1; bus.i_t = 32'd1;
      @(negedge clk);
      bus.i_start = 1'b0;
      while (cyc < e0 + W + 1) @(negedge clk);
      bus.i_start = 1'b1; bus.i_op = OP_MULTU; bus.i_s = 32'd9; bus.i_t = 32'd9;
      @(negedge clk);
      bus.i_start = 1'b0;
      wait_done("busy_ignore");
      repeat (40) @(negedge clk);

`ifdef MIPS_MULDIV_ABORT_EN
      issue("abort", OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 0, 0, 0, 1'b0, e0);
      repeat (4) @(negedge clk);
      bus.i_abort = 1'b1;
      @(negedge clk);
      bus.i_abort = 1'b0;
      check("abort_idle", 128'({bus.o_busy, bus.o_done}), 128'(0));
      check("abort_retain", outs(), 128'({32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1, 1'b0}));
      repeat (45) @(negedge clk);
`endif

      // Reset while running: everything clears at once, no done.
      issue("reset_mid", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 0, 0, 1'b0, e0);
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("reset_mid_run", 128'({bus.o_busy, bus.o_done, outs()}), 128'(0));
      @(negedge clk);
      reset_n = 1'b1;
      repeat (45) @(negedge clk);

      check("done_count", 128'(n_done), 128'(n_pushed));
      check("scoreboard_empty", 128'(sb.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish by 200000, expected finish");
      $fatal(1, "timeout");
   end

endmodule
